// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: logic ops, add/sub, signed compare and flags.
// Shift opcodes pass b through (the zero-distance shift); illegal codes give zero.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             v,
  output logic             cout
);

  logic             sub_s;
  logic [WIDTH-1:0] bx_s;
  logic [WIDTH:0]   sum_s;
  logic             cin_msb_s;
  logic             ovf_s;

  // SLT reuses the subtractor so its sign/overflow match SUB exactly
  assign sub_s     = (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);
  assign bx_s      = sub_s ? ~b : b;
  assign sum_s     = {1'b0, a} + {1'b0, bx_s} + {{WIDTH{1'b0}}, sub_s};
  assign cin_msb_s = a[WIDTH-1] ^ bx_s[WIDTH-1] ^ sum_s[WIDTH-1];
  assign ovf_s     = cin_msb_s ^ sum_s[WIDTH];
  assign z         = (r == {WIDTH{1'b0}});

  // Result and arithmetic flag selection
  always_comb begin
    r    = {WIDTH{1'b0}};
    v    = 1'b0;
    cout = 1'b0;
    case (alu_ctrl)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD, OP_SUB: begin
        r    = sum_s[WIDTH-1:0];
        v    = ovf_s;
        cout = sum_s[WIDTH];
      end
      OP_SLT: r = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
      OP_SLL, OP_SRL: r = b;
      default: r = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_core, bit-serial shifts and a
// shift-add multiplier. Outputs are registered and only change with done.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] mul_hi,
  output logic             z,
  output logic             v,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_r;
  logic [CW-1:0]      cnt_r;
  logic               left_r;
  logic [WIDTH-1:0]   sh_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   r_r;
  logic [WIDTH-1:0]   hi_r;
  logic               z_r;
  logic               v_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH-1:0]   core_r_s;
  logic               core_z_s;
  logic               core_v_s;
  logic               core_c_s;
  logic [WIDTH-1:0]   sh_next_s;
  logic [WIDTH:0]     madd_s;
  logic [2*WIDTH-1:0] prod_next_s;
  logic               last_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .r        (core_r_s),
    .z        (core_z_s),
    .v        (core_v_s),
    .cout     (core_c_s)
  );

  // Product register holds {partial high, remaining multiplier bits}
  assign sh_next_s   = left_r ? {sh_r[WIDTH-2:0], 1'b0} : {1'b0, sh_r[WIDTH-1:1]};
  assign madd_s      = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
  assign prod_next_s = prod_r[0] ? {madd_s, prod_r[WIDTH-1:1]}
                                 : {1'b0, prod_r[2*WIDTH-1:1]};
  assign last_s      = (cnt_r == CW'(1));

  // FSM, iteration datapath and registered result/flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      left_r  <= 1'b0;
      sh_r    <= {WIDTH{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      r_r     <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      z_r     <= 1'b1;
      v_r     <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if ((alu_ctrl == OP_SLL || alu_ctrl == OP_SRL) && (shamt != {SHW{1'b0}})) begin
              sh_r    <= b;
              left_r  <= (alu_ctrl == OP_SLL);
              cnt_r   <= CW'(shamt);
              busy_r  <= 1'b1;
              state_r <= ST_SHIFT;
            end else if (alu_ctrl == OP_MUL) begin
              prod_r  <= {{WIDTH{1'b0}}, b};
              mcand_r <= a;
              cnt_r   <= CW'(WIDTH);
              busy_r  <= 1'b1;
              state_r <= ST_MUL;
            end else begin
              r_r    <= core_r_s;
              hi_r   <= {WIDTH{1'b0}};
              z_r    <= core_z_s;
              v_r    <= core_v_s;
              cout_r <= core_c_s;
              done_r <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          sh_r  <= sh_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (last_s) begin
            r_r     <= sh_next_s;
            hi_r    <= {WIDTH{1'b0}};
            z_r     <= (sh_next_s == {WIDTH{1'b0}});
            v_r     <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          prod_r <= prod_next_s;
          cnt_r  <= cnt_r - CW'(1);
          if (last_s) begin
            r_r     <= prod_next_s[WIDTH-1:0];
            hi_r    <= prod_next_s[2*WIDTH-1:WIDTH];
            z_r     <= (prod_next_s == {(2*WIDTH){1'b0}});
            v_r     <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign r      = r_r;
  assign mul_hi = hi_r;
  assign z      = z_r;
  assign v      = v_r;
  assign cout   = cout_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: a 32-bit and an 8-bit instance
// driven from one linear sequence; expectations are queued at issue time.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start32, start8;
  logic [3:0]  ctrl32, ctrl8;
  logic [31:0] a32, b32;
  logic [4:0]  sh32;
  logic [7:0]  a8, b8;
  logic [2:0]  sh8;
  logic [31:0] r32, hi32;
  logic [7:0]  r8, hi8;
  logic        z32, v32, c32, busy32, done32;
  logic        z8, v8, c8, busy8, done8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [63:0] r;
    logic [63:0] hi;
    logic        z;
    logic        v;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .alu_ctrl(ctrl32),
    .a(a32), .b(b32), .shamt(sh32), .r(r32), .mul_hi(hi32),
    .z(z32), .v(v32), .cout(c32), .busy(busy32), .done(done32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_ctrl(ctrl8),
    .a(a8), .b(b8), .shamt(sh8), .r(r8), .mul_hi(hi8),
    .z(z8), .v(v8), .cout(c8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input bit w8, output logic [63:0] r, output logic [63:0] hi,
                      output logic z, output logic v, output logic c,
                      output logic busy, output logic done);
    if (w8) begin
      r = {56'd0, r8}; hi = {56'd0, hi8}; z = z8; v = v8; c = c8; busy = busy8; done = done8;
    end else begin
      r = {32'd0, r32}; hi = {32'd0, hi32}; z = z32; v = v32; c = c32; busy = busy32; done = done32;
    end
  endtask

  task automatic expect_op(input string tag, input logic [63:0] r, input logic [63:0] hi,
                           input logic z, input logic v, input logic c, input int lat);
    exp_t e;
    e.tag = tag; e.r = r; e.hi = hi; e.z = z; e.v = v; e.c = c; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge of cycle k+1. Operands are
  // scrambled right after acceptance so in-flight ops must not re-sample them.
  task automatic issue(input bit w8, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] sh);
    if (w8) begin
      ctrl8 = op; a8 = a[7:0]; b8 = b[7:0]; sh8 = sh[2:0]; start8 = 1'b1;
    end else begin
      ctrl32 = op; a32 = a[31:0]; b32 = b[31:0]; sh32 = sh[4:0]; start32 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    a8 = ~a8; b8 = ~b8; sh8 = ~sh8; ctrl8 = 4'b0001;
    a32 = ~a32; b32 = ~b32; sh32 = ~sh32; ctrl32 = 4'b0001;
  endtask

  task automatic wait_done(input bit w8, input int inject_at);
    exp_t        e;
    logic [63:0] r, hi;
    logic        z, v, c, busy, done;
    int          lat = 1;
    int          busy_cnt = 0;
    snap(w8, r, hi, z, v, c, busy, done);
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lat == inject_at) begin
        ctrl32 = 4'b0010; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
        ctrl8  = 4'b0010; a8  = 8'd1;  b8  = 8'd1;  start8  = 1'b1;
      end
      @(negedge clk);
      start32 = 1'b0; start8 = 1'b0;
      lat++;
      snap(w8, r, hi, z, v, c, busy, done);
    end
    e = sb.pop_front();
    chk({e.tag, "_done"}, {63'd0, done}, 64'd1);
    chk({e.tag, "_lat"}, 64'(lat), 64'(e.lat));
    chk({e.tag, "_busycyc"}, 64'(busy_cnt), 64'(e.lat - 1));
    chk({e.tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({e.tag, "_r"}, r, e.r);
    chk({e.tag, "_hi"}, hi, e.hi);
    chk({e.tag, "_zvc"}, {61'd0, z, v, c}, {61'd0, e.z, e.v, e.c});
  endtask

  initial begin
    logic [63:0] r, hi;
    logic        z, v, c, busy, done;
    int          stray;
    rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0;
    ctrl32 = 4'd0; ctrl8 = 4'd0; a32 = 32'd0; b32 = 32'd0; sh32 = 5'd0;
    a8 = 8'd0; b8 = 8'd0; sh8 = 3'd0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      snap(w[0], r, hi, z, v, c, busy, done);
      chk("reset_r", r, 64'd0);
      chk("reset_hi", hi, 64'd0);
      chk("reset_flags", {59'd0, z, v, c, busy, done}, {59'd0, 5'b10000});
    end
    rst_n = 1'b1;
    @(negedge clk);

    expect_op("add_ovf", 64'h8000_0000, 64'd0, 1'b0, 1'b1, 1'b0, 1);
    issue(1'b0, 4'b0010, 64'h7FFF_FFFF, 64'd1, 6'd0); wait_done(1'b0, -1);
    expect_op("sub_eq", 64'd0, 64'd0, 1'b1, 1'b0, 1'b1, 1);
    issue(1'b0, 4'b0110, 64'd5, 64'd5, 6'd0); wait_done(1'b0, -1);
    expect_op("slt_neg", 64'd1, 64'd0, 1'b0, 1'b0, 1'b0, 1);
    issue(1'b0, 4'b0111, 64'hFFFF_FFFF, 64'd1, 6'd0); wait_done(1'b0, -1);
    expect_op("and", 64'h00F0_1234, 64'd0, 1'b0, 1'b0, 1'b0, 1);
    issue(1'b0, 4'b0000, 64'hF0F0_1234, 64'h0FF0_FFFF, 6'd0); wait_done(1'b0, -1);
    expect_op("or", 64'hFFF0_FFFF, 64'd0, 1'b0, 1'b0, 1'b0, 1);
    issue(1'b0, 4'b0001, 64'hF0F0_1234, 64'h0FF0_FFFF, 6'd0); wait_done(1'b0, -1);
    expect_op("nor", 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1);
    issue(1'b0, 4'b1100, 64'h0F0F_0F0F, 64'hF0F0_F0F0, 6'd0); wait_done(1'b0, -1);
    expect_op("illegal", 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1);
    issue(1'b0, 4'b1111, 64'd5, 64'd7, 6'd3); wait_done(1'b0, -1);
    expect_op("sll0", 64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 1);
    issue(1'b0, 4'b1000, 64'd9, 64'h1234, 6'd0); wait_done(1'b0, -1);

    // Long shift with a stray start pulsed while busy
    expect_op("sll31", 64'h8000_0000, 64'd0, 1'b0, 1'b0, 1'b0, 32);
    issue(1'b0, 4'b1000, 64'd0, 64'd1, 6'd31); wait_done(1'b0, 10);
    @(negedge clk);
    chk("sll31_nodone_after", {63'd0, done32}, 64'd0);

    expect_op("srl4", 64'h0800_0000, 64'd0, 1'b0, 1'b0, 1'b0, 5);
    issue(1'b0, 4'b1001, 64'd0, 64'h8000_0000, 6'd4); wait_done(1'b0, -1);
    expect_op("mul_max", 64'h0000_0001, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33);
    issue(1'b0, 4'b1010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 6'd0); wait_done(1'b0, -1);
    expect_op("mul_small", 64'd15, 64'd0, 1'b0, 1'b0, 1'b0, 33);
    issue(1'b0, 4'b1010, 64'd3, 64'd5, 6'd0); wait_done(1'b0, -1);

    // Reset in the middle of a multiply, with start held during reset
    issue(1'b0, 4'b1010, 64'h1234, 64'h5678, 6'd0);
    repeat (9) @(negedge clk);
    chk("mulrst_busy_before", {63'd0, busy32}, 64'd1);
    rst_n = 1'b0; ctrl32 = 4'b0010; a32 = 32'd7; b32 = 32'd8; start32 = 1'b1;
    @(negedge clk);
    chk("mulrst_r", {32'd0, r32}, 64'd0);
    chk("mulrst_hi", {32'd0, hi32}, 64'd0);
    chk("mulrst_flags", {61'd0, z32, busy32, done32}, {61'd0, 3'b100});
    rst_n = 1'b1; start32 = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || busy32) stray++;
    end
    chk("mulrst_no_done", 64'(stray), 64'd0);
    expect_op("add_after_rst", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 1);
    issue(1'b0, 4'b0010, 64'd2, 64'd3, 6'd0); wait_done(1'b0, -1);

    // 8-bit build: shift then back-to-back starts in each done cycle
    expect_op("w8_srl7", 64'h01, 64'd0, 1'b0, 1'b0, 1'b0, 8);
    issue(1'b1, 4'b1001, 64'd0, 64'h80, 6'd7); wait_done(1'b1, -1);
    expect_op("w8_b2b_add", 64'h80, 64'd0, 1'b0, 1'b1, 1'b0, 1);
    issue(1'b1, 4'b0010, 64'h7F, 64'h01, 6'd0); wait_done(1'b1, -1);
    expect_op("w8_b2b_mul", 64'h01, 64'hFE, 1'b0, 1'b0, 1'b0, 9);
    issue(1'b1, 4'b1010, 64'hFF, 64'hFF, 6'd0); wait_done(1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
